// File: rtl/btb_update_arbiter.sv
// Round-robin arbiter feeding a coalescing FIFO in front of the single BTB update port.
// Queued pcs are kept unique: a repeat pc rewrites the queued target instead of allocating.

module btb_uq_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alloc,
    input  logic         merge,
    input  logic         pop,
    input  logic [W-1:0] pc_in,
    input  logic [W-1:0] tgt_in,
    output logic         valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] target
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid  <= 1'b0;
            pc     <= '0;
            target <= '0;
        end else if (alloc) begin
            valid  <= 1'b1;
            pc     <= pc_in;
            target <= tgt_in;
        end else begin
            if (merge) target <= tgt_in;
            if (pop)   valid  <= 1'b0;
        end
    end
endmodule

module btb_update_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int QUEUE_DEPTH     = 4,
    parameter int INSTR_MEM_IDX_W = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*INSTR_MEM_IDX_W-1:0] req_pc,
    input  logic [NUM_REQ*INSTR_MEM_IDX_W-1:0] req_target,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               pause,
    output logic                               update_valid,
    output logic [INSTR_MEM_IDX_W-1:0]         update_pc,
    output logic [INSTR_MEM_IDX_W-1:0]         update_target,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count,
    output logic                               coalesce
);
    localparam int W     = INSTR_MEM_IDX_W;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
    localparam int RR_W  = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [RR_W-1:0]  rr_ptr, acc_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0][W-1:0] pc_v, tgt_v;
    logic [QUEUE_DEPTH-1:0] ent_vld, ent_alloc, ent_merge, ent_pop, match;
    logic [QUEUE_DEPTH-1:0][W-1:0] ent_pc, ent_tgt;
    logic [W-1:0] acc_pc, acc_tgt;
    logic full, empty, pop, acc, hit, alloc;

    assign pc_v  = req_pc;
    assign tgt_v = req_target;

    assign full  = (count == CNT_W'(QUEUE_DEPTH));
    assign empty = (count == '0);

    assign update_valid  = rst && !empty && !pause;
    assign update_pc     = empty ? '0 : ent_pc[rd_ptr];
    assign update_target = empty ? '0 : ent_tgt[rd_ptr];
    assign pop           = update_valid;
    assign q_count       = count;

    always_comb begin : p_grant
        int j;
        logic found;
        j       = 0;
        found   = 1'b0;
        gnt     = '0;
        acc_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                acc_idx = RR_W'(j);
            end
        end
    end

    // No full bypass: a pop in the same cycle does not open a slot for acceptance.
    assign req_ready = (rst && !full) ? gnt : '0;
    assign acc       = |req_ready;
    assign acc_pc    = pc_v[acc_idx];
    assign acc_tgt   = tgt_v[acc_idx];

    // The popping head is excluded so a same-pc request lands behind it, not in a retiring slot.
    always_comb begin
        match     = '0;
        ent_alloc = '0;
        ent_merge = '0;
        ent_pop   = '0;
        for (int e = 0; e < QUEUE_DEPTH; e++) begin
            match[e]   = ent_vld[e] && (ent_pc[e] == acc_pc) &&
                         !(pop && (rd_ptr == PTR_W'(e)));
            ent_pop[e] = pop && (rd_ptr == PTR_W'(e));
        end
        for (int e = 0; e < QUEUE_DEPTH; e++) begin
            ent_merge[e] = acc && match[e];
            ent_alloc[e] = acc && !(|match) && (wr_ptr == PTR_W'(e));
        end
    end

    assign hit   = |match;
    assign alloc = acc && !hit;

    for (genvar e = 0; e < QUEUE_DEPTH; e++) begin : g_ent
        btb_uq_entry #(.W(W)) u_ent (
            .clk    (clk),
            .rst    (rst),
            .alloc  (ent_alloc[e]),
            .merge  (ent_merge[e]),
            .pop    (ent_pop[e]),
            .pc_in  (acc_pc),
            .tgt_in (acc_tgt),
            .valid  (ent_vld[e]),
            .pc     (ent_pc[e]),
            .target (ent_tgt[e])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rr_ptr   <= '0;
            coalesce <= 1'b0;
        end else begin
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({alloc, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (acc) rr_ptr <= (acc_idx == RR_W'(NUM_REQ-1)) ? '0 : acc_idx + RR_W'(1);
            coalesce <= acc && hit;
        end
    end
endmodule

// File: tb/tb_btb_update_arbiter.sv
// Directed bench for btb_update_arbiter: reset, round-robin, full, coalescing, reset mid-drain.
module tb_btb_update_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_pc;
    logic [15:0] req_target;
    logic [1:0]  req_ready;
    logic        pause;
    logic        update_valid;
    logic [7:0]  update_pc;
    logic [7:0]  update_target;
    logic [2:0]  q_count;
    logic        coalesce;

    int total = 0;
    int bad   = 0;

    btb_update_arbiter #(.NUM_REQ(2), .QUEUE_DEPTH(4), .INSTR_MEM_IDX_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_pc        (req_pc),
        .req_target    (req_target),
        .req_ready     (req_ready),
        .pause         (pause),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .q_count       (q_count),
        .coalesce      (coalesce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] p0, input logic [7:0] t0,
                         input logic [7:0] p1, input logic [7:0] t1);
        req_valid  = v;
        req_pc     = {p1, p0};
        req_target = {t1, t0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with both requesters asking
        rst = 1'b0; pause = 1'b0;
        drive(2'b11, 8'h20, 8'h60, 8'h30, 8'h70);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_uv", update_valid, 1'b0);
        chk("rst_qc", q_count, 3'd0);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("first_grant", req_ready, 2'b01);
        chk("first_uv", update_valid, 1'b0);

        // round-robin alternation
        step(); drive(2'b11, 8'h21, 8'h61, 8'h30, 8'h70);
        @(negedge clk);
        chk("rr1_ready", req_ready, 2'b10);
        chk("rr1_pc", update_pc, 8'h20);
        chk("rr1_tgt", update_target, 8'h60);
        chk("rr1_qc", q_count, 3'd1);
        step(); drive(2'b11, 8'h21, 8'h61, 8'h31, 8'h71);
        @(negedge clk);
        chk("rr2_ready", req_ready, 2'b01);
        chk("rr2_pc", update_pc, 8'h30);
        chk("rr2_tgt", update_target, 8'h70);
        chk("rr2_qc", q_count, 3'd1);
        step(); drive(2'b10, 8'h22, 8'h62, 8'h31, 8'h71);
        @(negedge clk);
        chk("rr3_ready", req_ready, 2'b10);
        chk("rr3_pc", update_pc, 8'h21);
        step(); drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("rr4_ready", req_ready, 2'b00);
        chk("rr4_pc", update_pc, 8'h31);
        chk("rr4_qc", q_count, 3'd1);
        step();
        @(negedge clk);
        chk("rr5_uv", update_valid, 1'b0);
        chk("rr5_qc", q_count, 3'd0);

        // fill to full under pause, then drain in order
        step(); pause = 1'b1; drive(2'b01, 8'h50, 8'h90, 8'h00, 8'h00);
        @(negedge clk);
        chk("full_acc", req_ready, 2'b01);
        step(); drive(2'b01, 8'h51, 8'h91, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h52, 8'h92, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h53, 8'h93, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h54, 8'h94, 8'h00, 8'h00);
        @(negedge clk);
        chk("full_qc", q_count, 3'd4);
        chk("full_ready", req_ready, 2'b00);
        chk("full_paused_uv", update_valid, 1'b0);
        step(); pause = 1'b0;
        @(negedge clk);
        chk("nobypass_ready", req_ready, 2'b00);
        chk("drain0_uv", update_valid, 1'b1);
        chk("drain0_pc", update_pc, 8'h50);
        chk("drain0_tgt", update_target, 8'h90);
        step(); drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("drain1_pc", update_pc, 8'h51);
        chk("drain1_qc", q_count, 3'd3);
        step();
        @(negedge clk);
        chk("drain2_pc", update_pc, 8'h52);
        step();
        @(negedge clk);
        chk("drain3_pc", update_pc, 8'h53);
        chk("drain3_tgt", update_target, 8'h93);
        step();
        @(negedge clk);
        chk("drained_uv", update_valid, 1'b0);
        chk("drained_qc", q_count, 3'd0);

        // coalesce into a paused entry
        step(); pause = 1'b1; drive(2'b01, 8'h10, 8'h40, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h10, 8'h80, 8'h00, 8'h00);
        @(negedge clk);
        chk("coal_pre_qc", q_count, 3'd1);
        chk("coal_pre_flag", coalesce, 1'b0);
        chk("coal_ready", req_ready, 2'b01);
        step(); pause = 1'b0; drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("coal_qc", q_count, 3'd1);
        chk("coal_flag", coalesce, 1'b1);
        chk("coal_pc", update_pc, 8'h10);
        chk("coal_tgt", update_target, 8'h80);
        step();
        @(negedge clk);
        chk("coal_post_qc", q_count, 3'd0);
        chk("coal_post_flag", coalesce, 1'b0);
        chk("coal_post_uv", update_valid, 1'b0);

        // same pc as the popping head must allocate a fresh entry
        step(); drive(2'b01, 8'h10, 8'h40, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h10, 8'h90, 8'h00, 8'h00);
        @(negedge clk);
        chk("cvp_ready", req_ready, 2'b01);
        chk("cvp_pc0", update_pc, 8'h10);
        chk("cvp_tgt0", update_target, 8'h40);
        step(); drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("cvp_qc", q_count, 3'd1);
        chk("cvp_flag", coalesce, 1'b0);
        chk("cvp_pc1", update_pc, 8'h10);
        chk("cvp_tgt1", update_target, 8'h90);
        step();
        @(negedge clk);
        chk("cvp_empty", q_count, 3'd0);

        // reset while draining
        step(); pause = 1'b1; drive(2'b01, 8'h60, 8'hA0, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h61, 8'hA1, 8'h00, 8'h00);
        step(); drive(2'b01, 8'h62, 8'hA2, 8'h00, 8'h00);
        step(); drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("mid_qc3", q_count, 3'd3);
        step(); pause = 1'b0;
        @(negedge clk);
        chk("mid_pc", update_pc, 8'h60);
        step();
        @(negedge clk);
        chk("mid_qc2", q_count, 3'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_uv", update_valid, 1'b0);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("post_rst_qc", q_count, 3'd0);
        chk("post_rst_uv", update_valid, 1'b0);
        chk("post_rst_pc", update_pc, 8'h00);
        drive(2'b11, 8'h70, 8'hB0, 8'h71, 8'hB1);
        #1;
        chk("post_rst_grant", req_ready, 2'b01);
        step(); drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_rst_qc1", q_count, 3'd1);
        chk("post_rst_head", update_pc, 8'h70);
        step();
        @(negedge clk);
        chk("final_uv", update_valid, 1'b0);
        chk("final_qc", q_count, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
